// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: arbiter FSM states and core-state encodings shared with the LSU.
// Also holds the small pointer-wrap helper used by the round-robin logic.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        READ_WAITING  = 2'd1,
        WRITE_WAITING = 2'd2,
        RELAY         = 2'd3
    } arb_state_t;

    typedef enum logic [2:0] {
        CORE_REQUEST = 3'b011,
        CORE_UPDATE  = 3'b110
    } core_state_t;

    function automatic int unsigned wrap_inc(
        input int unsigned idx,
        input int unsigned n
    );
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin find-first starting at i_ptr.
// A consumer with both requests pending reports is_read so reads go first.
module rr_picker #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_rd,
    input  logic [N-1:0]  i_wr,
    input  logic [IW-1:0] i_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_idx,
    output logic          o_is_read
);

    function automatic logic [IW-1:0] slot(
        input logic [IW-1:0] p,
        input int            k
    );
        return IW'((int'(p) + k) % N);
    endfunction

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        o_found   = 1'b0;
        o_idx     = '0;
        o_is_read = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_rd[slot(i_ptr, k)] || i_wr[slot(i_ptr, k)]) begin
                o_found   = 1'b1;
                o_idx     = slot(i_ptr, k);
                o_is_read = i_rd[slot(i_ptr, k)];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one data-memory channel across LSUs.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_CONSUMERS  = 4,
    parameter  int ADDR_BITS      = 16,
    parameter  int DATA_BITS      = 8,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int IDW            = $clog2(NUM_CONSUMERS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready,
    output logic                               busy,
    output logic [IDW-1:0]                     grant_id,
    output logic                               timeout_error
);

    localparam int N = NUM_CONSUMERS;

    arb_state_t           r_state, w_state_nxt;
    logic [IDW-1:0]       r_ptr, w_ptr_nxt;
    logic [IDW-1:0]       r_grant, w_grant_nxt;
    logic                 r_mrv, w_mrv_nxt;
    logic                 r_mwv, w_mwv_nxt;
    logic [ADDR_BITS-1:0] r_mra, w_mra_nxt;
    logic [ADDR_BITS-1:0] r_mwa, w_mwa_nxt;
    logic [DATA_BITS-1:0] r_mwd, w_mwd_nxt;
    logic [N-1:0]         r_crr, w_crr_nxt;
    logic [N-1:0]         r_cwr, w_cwr_nxt;
    logic [N*DATA_BITS-1:0] r_crd, w_crd_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_tmo_err, w_tmo_err_nxt;

    logic                 w_found;
    logic                 w_is_read;
    logic [IDW-1:0]       w_pick;
    logic                 w_tmo_hit;
    logic                 w_relay_done;

    rr_picker #(
        .N (N)
    ) u_pick (
        .i_rd      (consumer_read_valid),
        .i_wr      (consumer_write_valid),
        .i_ptr     (r_ptr),
        .o_found   (w_found),
        .o_idx     (w_pick),
        .o_is_read (w_is_read)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCW-1:0] r_tcnt;
    logic           w_waiting;

    assign w_waiting =
        (r_state == READ_WAITING  && !mem_read_ready) ||
        (r_state == WRITE_WAITING && !mem_write_ready);
    assign w_tmo_hit =
        w_waiting && (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));

    // Held at zero while idle, so every WAITING entry starts fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcnt <= '0;
        end else if (r_state == IDLE) begin
            r_tcnt <= '0;
        end else if (w_waiting && !w_tmo_hit) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end
`else
    logic w_unused_tmo;

    assign w_tmo_hit    = 1'b0;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

    // Ready is held until the served consumer drops the matching valid.
    assign w_relay_done =
        ((r_crr != '0) && !consumer_read_valid[r_grant]) ||
        ((r_cwr != '0) && !consumer_write_valid[r_grant]);

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_grant_nxt   = r_grant;
        w_mrv_nxt     = r_mrv;
        w_mwv_nxt     = r_mwv;
        w_mra_nxt     = r_mra;
        w_mwa_nxt     = r_mwa;
        w_mwd_nxt     = r_mwd;
        w_crr_nxt     = r_crr;
        w_cwr_nxt     = r_cwr;
        w_crd_nxt     = r_crd;
        w_tmo_err_nxt = r_tmo_err;

        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_pick;
                    if (w_is_read) begin
                        w_mrv_nxt   = 1'b1;
                        w_mra_nxt   = consumer_read_address[w_pick*ADDR_BITS +: ADDR_BITS];
                        w_state_nxt = READ_WAITING;
                    end else begin
                        w_mwv_nxt   = 1'b1;
                        w_mwa_nxt   = consumer_write_address[w_pick*ADDR_BITS +: ADDR_BITS];
                        w_mwd_nxt   = consumer_write_data[w_pick*DATA_BITS +: DATA_BITS];
                        w_state_nxt = WRITE_WAITING;
                    end
                end
            end
            READ_WAITING: begin
                if (mem_read_ready || w_tmo_hit) begin
                    w_mrv_nxt            = 1'b0;
                    w_crr_nxt[r_grant]   = 1'b1;
                    w_crd_nxt[r_grant*DATA_BITS +: DATA_BITS] =
                        w_tmo_hit ? '0 : mem_read_data;
                    w_tmo_err_nxt        = r_tmo_err | w_tmo_hit;
                    w_state_nxt          = RELAY;
                end
            end
            WRITE_WAITING: begin
                if (mem_write_ready || w_tmo_hit) begin
                    w_mwv_nxt          = 1'b0;
                    w_cwr_nxt[r_grant] = 1'b1;
                    w_tmo_err_nxt      = r_tmo_err | w_tmo_hit;
                    w_state_nxt        = RELAY;
                end
            end
            RELAY: begin
                if (w_relay_done) begin
                    w_crr_nxt   = '0;
                    w_cwr_nxt   = '0;
                    w_ptr_nxt   = IDW'(wrap_inc(32'(r_grant), N));
                    w_state_nxt = IDLE;
                end
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_mrv     <= 1'b0;
            r_mwv     <= 1'b0;
            r_mra     <= '0;
            r_mwa     <= '0;
            r_mwd     <= '0;
            r_crr     <= '0;
            r_cwr     <= '0;
            r_crd     <= '0;
            r_busy    <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_grant   <= w_grant_nxt;
            r_mrv     <= w_mrv_nxt;
            r_mwv     <= w_mwv_nxt;
            r_mra     <= w_mra_nxt;
            r_mwa     <= w_mwa_nxt;
            r_mwd     <= w_mwd_nxt;
            r_crr     <= w_crr_nxt;
            r_cwr     <= w_cwr_nxt;
            r_crd     <= w_crd_nxt;
            r_busy    <= w_busy_nxt;
            r_tmo_err <= w_tmo_err_nxt;
        end
    end

    assign consumer_read_ready  = r_crr;
    assign consumer_read_data   = r_crd;
    assign consumer_write_ready = r_cwr;
    assign mem_read_valid       = r_mrv;
    assign mem_read_address     = r_mra;
    assign mem_write_valid      = r_mwv;
    assign mem_write_address    = r_mwa;
    assign mem_write_data       = r_mwd;
    assign busy                 = r_busy;
    assign grant_id             = r_grant;
    assign timeout_error        = r_tmo_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a
// transaction-level round-robin model and a behavioural memory.
module tb_mem_arbiter;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int IW  = 2;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic [N-1:0]    c_rv, c_wv, c_rr, c_wr;
    logic [N*AW-1:0] c_ra, c_wa;
    logic [N*DW-1:0] c_wd, c_rd;
    logic            mrv, mwv, busy, tmo_err;
    logic [AW-1:0]   mra, mwa;
    logic [DW-1:0]   mwd;
    logic [IW-1:0]   gid;
    logic            mrr = 1'b0;
    logic            mwr = 1'b0;
    logic [DW-1:0]   mrd = '0;

    bit            rv [N];
    bit            wv [N];
    logic [AW-1:0] ra [N];
    logic [AW-1:0] wa [N];
    logic [DW-1:0] wd [N];
    logic [DW-1:0] last_rd [N];
    int            rd_pulses [N];
    int            wr_pulses [N];
    bit [DW-1:0]   mem_arr [256];

    int total = 0;
    int bad   = 0;
    int phase = 0;
    int exp_id = 0;
    int mptr = 0;
    int mcnt = 0;
    int mem_dly = 0;
    int hold = 0;
    int hold_left = 0;
    bit exp_rd = 1'b0;
    logic [DW-1:0] exp_data = '0;
    bit eng = 1'b1;
    bit gen_on = 1'b0;
    int gq_id [$];
    int gq_rd [$];

    always #5 clk = ~clk;

    always_comb begin
        c_rv = '0;
        c_wv = '0;
        c_ra = '0;
        c_wa = '0;
        c_wd = '0;
        for (int i = 0; i < N; i++) begin
            c_rv[i]           = rv[i];
            c_wv[i]           = wv[i];
            c_ra[i*AW +: AW]  = ra[i];
            c_wa[i*AW +: AW]  = wa[i];
            c_wd[i*DW +: DW]  = wd[i];
        end
    end

    mem_arbiter #(
        .NUM_CONSUMERS  (N),
        .ADDR_BITS      (AW),
        .DATA_BITS      (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (c_rv),
        .consumer_read_address  (c_ra),
        .consumer_read_ready    (c_rr),
        .consumer_read_data     (c_rd),
        .consumer_write_valid   (c_wv),
        .consumer_write_address (c_wa),
        .consumer_write_data    (c_wd),
        .consumer_write_ready   (c_wr),
        .mem_read_valid         (mrv),
        .mem_read_address       (mra),
        .mem_read_ready         (mrr),
        .mem_read_data          (mrd),
        .mem_write_valid        (mwv),
        .mem_write_address      (mwa),
        .mem_write_data         (mwd),
        .mem_write_ready        (mwr),
        .busy                   (busy),
        .grant_id               (gid),
        .timeout_error          (tmo_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) p |= rv[i] | wv[i];
        return p;
    endfunction

    // Reference arbitration rule: first requester from the pointer, reads first.
    task automatic pick();
        bit hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            int i = (mptr + k) % N;
            if (!hit && (rv[i] || wv[i])) begin
                hit    = 1'b1;
                exp_id = i;
                exp_rd = rv[i];
            end
        end
    endtask

    task automatic respond();
        if (mem_dly == -2) return;
        if (mcnt == 0) begin
            if (exp_rd) begin
                mrr      = 1'b1;
                mrd      = mem_arr[mra[7:0]];
                exp_data = mrd;
            end else begin
                mwr = 1'b1;
                mem_arr[mwa[7:0]] = mwd;
            end
            phase = 2;
        end else begin
            mcnt--;
        end
    endtask

    task automatic relay();
        if (hold_left == 0) begin
            if (exp_rd) rv[exp_id] = 1'b0;
            else        wv[exp_id] = 1'b0;
            phase = 3;
        end else begin
            hold_left--;
            phase = 4;
        end
    endtask

    task automatic step();
        int bid;
        logic [N*DW-1:0] exp_rdv;
        @(negedge clk);
        if (!eng) return;
        chk("mem_excl", 32'(mrv & mwv), 0);
        chk("rdy_onehot", 32'($onehot0({c_rr, c_wr})), 1);
        bid = (phase == 1 || phase == 2 || phase == 4) ? exp_id : -1;
        case (phase)
            0: begin
                chk("grant_taken", 32'(mrv | mwv), 32'(pending()));
                if (mrv || mwv) begin
                    pick();
                    chk("grant_id", 32'(gid), exp_id);
                    chk("grant_rd", 32'(mrv), 32'(exp_rd));
                    chk("busy_on", 32'(busy), 1);
                    if (exp_rd) begin
                        chk("rd_addr", 32'(mra), 32'(ra[exp_id]));
                    end else begin
                        chk("wr_addr", 32'(mwa), 32'(wa[exp_id]));
                        chk("wr_data", 32'(mwd), 32'(wd[exp_id]));
                    end
                    gq_id.push_back(exp_id);
                    gq_rd.push_back(int'(exp_rd));
                    mptr  = (exp_id + 1) % N;
                    mcnt  = (mem_dly == -1) ? int'($urandom_range(0, 3)) : mem_dly;
                    phase = 1;
                    respond();
                end else begin
                    chk("idle_busy", 32'(busy), 0);
                end
            end
            1: begin
                chk("wait_valid", 32'(exp_rd ? mrv : mwv), 1);
                chk("wait_nordy", 32'(c_rr | c_wr), 0);
                respond();
            end
            2: begin
                mrr = 1'b0;
                mwr = 1'b0;
                chk("done_mv", 32'(mrv | mwv), 0);
                chk("rdy_r", 32'(c_rr), exp_rd ? (1 << exp_id) : 0);
                chk("rdy_w", 32'(c_wr), exp_rd ? 0 : (1 << exp_id));
                if (exp_rd) begin
                    chk("rdata", 32'(c_rd[exp_id*DW +: DW]), 32'(exp_data));
                    last_rd[exp_id] = exp_data;
                    rd_pulses[exp_id]++;
                end else begin
                    wr_pulses[exp_id]++;
                end
                hold_left = (hold < 0) ? int'($urandom_range(0, 2)) : hold;
                relay();
            end
            4: begin
                chk("rdy_hold", 32'(exp_rd ? c_rr : c_wr), 1 << exp_id);
                relay();
            end
            default: begin
                chk("relay_clr", 32'({c_rr, c_wr}), 0);
                chk("relay_busy", 32'(busy), 0);
                for (int i = 0; i < N; i++) exp_rdv[i*DW +: DW] = last_rd[i];
                chk("rdata_keep", 32'(c_rd), 32'(exp_rdv));
                phase = 0;
            end
        endcase
        if (gen_on) begin
            for (int i = 0; i < N; i++) begin
                if (i != bid && !rv[i] && $urandom_range(0, 5) == 0) begin
                    rv[i] = 1'b1;
                    ra[i] = AW'($urandom_range(0, 255));
                end
                if (i != bid && !wv[i] && $urandom_range(0, 7) == 0) begin
                    wv[i] = 1'b1;
                    wa[i] = AW'($urandom_range(0, 255));
                    wd[i] = DW'($urandom);
                end
            end
        end
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((phase != 0 || pending()) && n < budget) begin
            step();
            n++;
        end
        chk("run_budget", 32'(n < budget), 1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b0;
            wv[i] = 1'b0;
            last_rd[i] = '0;
        end
        mrr   = 1'b0;
        mwr   = 1'b0;
        phase = 0;
        mptr  = 0;
        gq_id.delete();
        gq_rd.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem_arr[i] = DW'(i * 7 + 3);
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            wa[i] = '0;
            wd[i] = '0;
            rd_pulses[i] = 0;
            wr_pulses[i] = 0;
        end
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst_mem", 32'({mrv, mwv, mra, mwa, mwd} != '0), 0);
        chk("rst_cons", 32'({c_rr, c_wr, c_rd} != '0), 0);
        chk("rst_misc", 32'({busy, gid, tmo_err}), 0);
        reset = 1'b1;

        // single read, held ready, then pointer at 3
        hold = 2;
        mem_dly = 2;
        mem_arr[8'h40] = 8'hA5;
        rv[2] = 1'b1;
        ra[2] = 16'h0040;
        run_idle(40);
        chk("sr_grant", gq_id[0], 2);
        chk("sr_data", 32'(c_rd[23:16]), 32'h00A5);
        hold = 0;
        gq_id.delete();
        rv[0] = 1'b1;
        ra[0] = 16'h0011;
        rv[3] = 1'b1;
        ra[3] = 16'h0033;
        run_idle(40);
        chk("ptr3_a", gq_id[0], 3);
        chk("ptr3_b", gq_id[1], 0);

        // fairness with immediate memory, two rounds
        do_reset();
        mem_dly = 0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                rv[i] = 1'b1;
                ra[i] = AW'(16 * i + r);
            end
            run_idle(80);
        end
        chk("fair_len", gq_id.size(), 2 * N);
        for (int k = 0; k < gq_id.size(); k++) chk("fair_order", gq_id[k], k % N);

        // read and write from the same consumer
        do_reset();
        mem_dly = 1;
        for (int i = 0; i < N; i++) begin
            rd_pulses[i] = 0;
            wr_pulses[i] = 0;
        end
        rv[1] = 1'b1;
        ra[1] = 16'h0010;
        wv[1] = 1'b1;
        wa[1] = 16'h0020;
        wd[1] = 8'h7E;
        run_idle(40);
        chk("rw_first_rd", gq_rd[0], 1);
        chk("rw_second_wr", gq_rd[1], 0);
        chk("rw_rd_pulse", rd_pulses[1], 1);
        chk("rw_wr_pulse", wr_pulses[1], 1);
        chk("rw_mem", 32'(mem_arr[8'h20]), 32'h7E);

        // mixed: pointer at 2, consumer 3 read beats consumer 0 write
        gq_id.delete();
        gq_rd.delete();
        wv[0] = 1'b1;
        wa[0] = 16'h0050;
        wd[0] = 8'h3C;
        rv[3] = 1'b1;
        ra[3] = 16'h0020;
        run_idle(40);
        chk("mix_first", gq_id[0], 3);
        chk("mix_second", gq_id[1], 0);
        chk("mix_rdata", 32'(c_rd[31:24]), 32'h7E);

        // drop valid mid-wait and before grant
        rd_pulses[2] = 0;
        rd_pulses[1] = 0;
        gq_id.delete();
        mem_dly = 3;
        rv[2] = 1'b1;
        ra[2] = 16'h0005;
        step();
        step();
        rv[2] = 1'b0;
        rv[1] = 1'b1;
        step();
        rv[1] = 1'b0;
        run_idle(40);
        chk("drop_pulse", rd_pulses[2], 1);
        chk("drop_unserved", rd_pulses[1], 0);
        chk("drop_grants", gq_id.size(), 1);

        // asynchronous reset mid-transaction
        mem_dly = -2;
        rv[0] = 1'b1;
        ra[0] = 16'h0077;
        step();
        step();
        chk("mid_wait", 32'(mrv), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst", 32'({mrv, mwv, busy, c_rr, c_wr, gid} != '0), 0);
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        mem_dly = 0;
        repeat (4) step();
        chk("post_rst", 32'({c_rr, c_wr, busy}), 0);

        // random traffic against the model
        do_reset();
        mem_dly = -1;
        hold = -1;
        gen_on = 1'b1;
        repeat (3000) step();
        gen_on = 1'b0;
        run_idle(400);
        chk("rand_grants", 32'(gq_id.size() > 50), 1);

`ifdef MEM_ARB_TIMEOUT_EN
        do_reset();
        eng = 1'b0;
        rv[0] = 1'b1;
        ra[0] = 16'h0009;
        n = 0;
        @(negedge clk);
        for (int c = 0; c < 40 && c_rr[0] == 1'b0; c++) begin
            if (mrv) n++;
            @(negedge clk);
        end
        chk("tmo_cycles", n, TMO);
        chk("tmo_valid", 32'(mrv), 0);
        chk("tmo_ready", 32'(c_rr), 1);
        chk("tmo_data", 32'(c_rd[7:0]), 0);
        chk("tmo_flag", 32'(tmo_err), 1);
        rv[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("tmo_sticky", 32'(tmo_err), 1);
        chk("tmo_idle", 32'(busy), 0);
`else
        n = 0;
        chk("tmo_tied", 32'(tmo_err) + n, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one data-memory channel between NUM_CONSUMERS per-thread LSUs in a core. Uses round-robin arbitration and serves one transaction at a time. Each consumer port uses the same valid/ready protocol the LSU already drives, so it connects directly. The memory side presents a single read/write valid/ready port to the external data memory.

Parameters:
NUM_CONSUMERS, 4, number of LSU requester ports (≥2)
ADDR_BITS, 16, memory address width
DATA_BITS, 8, memory data width
TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (asserted at 0)
consumer_read_valid  in  NUM_CONSUMERS  per-LSU read request
consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed, consumer i at [i*ADDR_BITS +: ADDR_BITS]
consumer_read_ready  out  NUM_CONSUMERS  read complete
consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed read data
consumer_write_valid  in  NUM_CONSUMERS  per-LSU write request
consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed
consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed
consumer_write_ready  out  NUM_CONSUMERS  write complete
mem_read_valid  out  1  read request to memory
mem_read_address  out  ADDR_BITS
mem_read_ready  in  1
mem_read_data  in  DATA_BITS
mem_write_valid  out  1  write request to memory
mem_write_address  out  ADDR_BITS
mem_write_data  out  DATA_BITS
mem_write_ready  in  1
busy  out  1  high in any state except IDLE
grant_id  out  $clog2(NUM_CONSUMERS)  currently served consumer
timeout_error  out  1  sticky watchdog flag

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, rr_ptr 0, consumer_read_data all 0.
- All outputs are registered.
- States: IDLE, READ_WAITING, WRITE_WAITING, RELAY.
- IDLE:
  - Scan consumers starting at rr_ptr, wrapping modulo NUM_CONSUMERS. The first consumer with read_valid or write_valid wins.
  - If a winner has both, read is served first; its write is taken in a later grant.
  - On a win: set grant_id, drive mem_*_valid=1 with that consumer's address (and data for writes), go to READ_WAITING or WRITE_WAITING.
  - No requests: stay in IDLE.
- READ_WAITING: on mem_read_ready, mem_read_valid←0, consumer_read_data[grant]←mem_read_data, consumer_read_ready[grant]←1, go to RELAY.
- WRITE_WAITING: on mem_write_ready, mem_write_valid←0, consumer_write_ready[grant]←1, go to RELAY.
- RELAY:
  - Hold the ready output until the granted consumer drops the matching valid.
  - Then clear ready, set rr_ptr←(grant+1) mod NUM_CONSUMERS, go to IDLE.
  - consumer_read_data[i] keeps its value until overwritten by consumer i's next read.
- Latency: a request sampled in IDLE at edge t gives mem valid after t. Memory ready sampled at edge t+k gives consumer ready after t+k. Minimum request-to-ready is 2 edges.
- Memory ready arriving while the arbiter is not in the matching WAITING state is ignored.
- A consumer dropping valid before being granted is not served; no state is retained for it.
- A consumer dropping valid mid-WAITING is ignored: the memory transaction completes and ready is pulsed once. In RELAY, valid is already low, so the arbiter returns to IDLE next cycle.
- Only one of mem_read_valid/mem_write_valid is ever high at a time. At most one consumer ready bit is high at a time.
- Reset mid-transaction aborts immediately; memory-side valids drop asynchronously.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined:
  - A counter runs in READ_WAITING/WRITE_WAITING and clears on state entry.
  - On reaching TIMEOUT_CYCLES without memory ready: drop the memory valid, return ready to the consumer (read data forced to 0), set timeout_error=1 (sticky until reset), go to RELAY.
- Undefined: no counter; the arbiter waits indefinitely and timeout_error is tied to 0.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE=2'd0, READ_WAITING=2'd1, WRITE_WAITING=2'd2, RELAY=2'd3), core_state encodings shared with the LSU (REQUEST=3'b011, UPDATE=3'b110).
- Sub-module rr_picker: combinational round-robin find-first from rr_ptr; outputs found, index and is_read.

Test Plan:
- Single read: consumer 2 read_valid, addr 0x0040; memory returns 0xA5 with ready 3 cycles after valid → mem_read_address=0x0040; consumer_read_data[2]=0xA5 and ready[2]=1 until valid drops; grant_id=2; rr_ptr=3.
- Fairness: all 4 consumers hold read_valid, memory answers immediately → grants in order 0,1,2,3; next round also starts at 0.
- Read+write same consumer: consumer 1 has read 0x10 and write 0x20/0x7E → read completes first, then mem_write_address=0x20, mem_write_data=0x7E; both readies pulse once.
- Mixed: consumer 0 write, consumer 3 read, rr_ptr=2 → consumer 3 read served before consumer 0 write; mem valids never overlap.
- Reset mid-transaction: reset=0 during READ_WAITING → all outputs 0 without waiting for a clock edge; after release, state IDLE and no ready pulse.
- Timeout (macro on, TIMEOUT_CYCLES=8): memory never readies → after 8 cycles mem_read_valid=0, consumer_read_ready=1, data 0x00, timeout_error=1 stays set.
